// File: rtl/cap_sense_scanner.sv
// cap_sense_scanner
//
// Drives the shared capacitive-sensor pin through a repeating
// discharge / charge / evaluate schedule and measures how many clock
// cycles each pad takes to rise while the pin is driven high. Each
// completed scan compares the counts against a threshold and updates a
// touched bitmap. A bit changes only when two consecutive scans agree.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-low reset
//   enable       1 = scan continuously, 0 = stop after the current scan
//   threshold    a count strictly above this value is a raw touch
//   sensors_in   asynchronous pad inputs, one per pad
//   sensors_out  shared drive pin (high only while charging)
//   touched      debounced touch bitmap
//   scan_done    one-cycle pulse in the cycle touched/counts update
//   busy         high whenever the scanner is not idle
//   count_sel    selects which pad's latched count appears on count_out
//   count_out    latched count of pad count_sel, 0 when out of range

module cap_sense_scanner #(
  parameter int NUM_SENSORS      = 9,
  parameter int CNT_W            = 16,
  parameter int DISCHARGE_CYCLES = 1000,
  parameter int CHARGE_TIMEOUT   = 4000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       threshold,
  input  logic [NUM_SENSORS-1:0] sensors_in,
  output logic                   sensors_out,
  output logic [NUM_SENSORS-1:0] touched,
  output logic                   scan_done,
  output logic                   busy,
  input  logic [3:0]             count_sel,
  output logic [CNT_W-1:0]       count_out
);

  localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(CHARGE_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    CHARGE    = 2'd2,
    EVAL      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0] sync1_q, sync2_q;
  logic [NUM_SENSORS-1:0] done_q, done_d;
  logic [NUM_SENSORS-1:0] raw_prev_q, raw_prev_d;
  logic [NUM_SENSORS-1:0] touched_q, touched_d;
  logic [NUM_SENSORS-1:0] raw;
  logic [CNT_W-1:0]       count_q [NUM_SENSORS];
  logic [CNT_W-1:0]       count_d [NUM_SENSORS];

  // Sequencer next-state and datapath. Every register holds by default.
  // The phase counter is reused by DISCHARGE and CHARGE, and it returns
  // to zero on every phase change, so each phase starts counting at 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    count_d    = count_q;
    raw_prev_d = raw_prev_q;
    touched_d  = touched_q;
    raw        = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = DISCHARGE;
        end
      end

      DISCHARGE: begin
        if (cnt_q == DIS_LAST) begin
          cnt_d   = '0;
          done_d  = '0;
          state_d = CHARGE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CHARGE: begin
        // The first cycle a pad is seen high latches the current charge
        // time. A pad that is already high on entry therefore reads 0.
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (sync2_q[i] && !done_q[i]) begin
            count_d[i] = cnt_q;
            done_d[i]  = 1'b1;
          end
        end
        // Pads still low at the timeout are pinned to the timeout value.
        // This keeps a dead or unconnected pad bounded and reads as touched.
        if (cnt_q == TIMEOUT) begin
          for (int i = 0; i < NUM_SENSORS; i++) begin
            if (!done_d[i]) begin
              count_d[i] = TIMEOUT;
              done_d[i]  = 1'b1;
            end
          end
          cnt_d   = '0;
          state_d = EVAL;
        end else if (&done_d) begin
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      EVAL: begin
        // A touched bit follows the raw result only when this scan and the
        // previous scan agree. A single noisy scan cannot flip it.
        for (int i = 0; i < NUM_SENSORS; i++) begin
          raw[i] = count_q[i] > threshold;
          if (raw[i] == raw_prev_q[i]) begin
            touched_d[i] = raw[i];
          end
        end
        raw_prev_d = raw;
        state_d    = enable ? DISCHARGE : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, plus a two-flop synchronizer per pad.
  // Reset is asynchronous. The drive pin is decoded from state_q, so an
  // abort drops the pin at once without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      done_q     <= '0;
      raw_prev_q <= '0;
      touched_q  <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync1_q    <= sensors_in;
      sync2_q    <= sync1_q;
      done_q     <= done_d;
      raw_prev_q <= raw_prev_d;
      touched_q  <= touched_d;
      count_q    <= count_d;
    end
  end

  // Read-back mux for the latched counts. A select beyond the last pad
  // reads zero.
  always_comb begin
    count_out = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (count_sel == 4'(i)) begin
        count_out = count_q[i];
      end
    end
  end

  assign sensors_out = (state_q == CHARGE);
  assign scan_done   = (state_q == EVAL);
  assign busy        = (state_q != IDLE);
  assign touched     = touched_q;

endmodule

// File: doc/cap_sense_scanner.md
Name: cap_sense_scanner

Overview:
Sequences the shared capacitive-sensor drive pin and measures the RC charge time of each of the 9 mole pads in parallel. Each scan produces a debounced touched bitmap that the processor reads through the skeleton's memory-mapped I/O. It replaces free-running sampling of capacitive_sensors_in with a deterministic discharge/charge/evaluate schedule. It sits in skeleton between the sensor pins and the processor's I/O decode.

Parameters:
NUM_SENSORS, 9, number of pads sharing the drive pin
CNT_W, 16, width of charge counters
DISCHARGE_CYCLES, 1000, cycles the drive pin is held low before each charge phase
CHARGE_TIMEOUT, 4000, maximum charge count; a pad that never rises reports this value

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = scan continuously, 0 = stop after the current scan
threshold  in  CNT_W  count strictly above this value = raw touch
sensors_in  in  NUM_SENSORS  asynchronous pad inputs (capacitive_sensors_in)
sensors_out  out  1  shared drive pin (capacitive_sensors_out)
touched  out  NUM_SENSORS  debounced touch bitmap
scan_done  out  1  one-cycle pulse when touched/counts update
busy  out  1  high in any state other than IDLE
count_sel  in  4  selects which pad count to read back
count_out  out  CNT_W  last latched count of pad count_sel; 0 if count_sel >= NUM_SENSORS

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; sensors_out, touched, scan_done and busy = 0; all latched counts, raw_prev and synchronizers cleared. Assertion in mid-scan aborts the scan immediately, with no scan_done.
- Input sync: 2-flop synchronizer per pad. All decisions use the synchronized bits.
- IDLE: sensors_out=0. If enable=1, go to DISCHARGE next cycle.
- DISCHARGE: sensors_out=0. Counter runs 0..DISCHARGE_CYCLES-1, then go to CHARGE.
- CHARGE: sensors_out=1. Counter starts at 0 in the first CHARGE cycle and increments by 1 per cycle.
  - Each pad has a done flag, cleared on CHARGE entry.
  - In the first cycle a pad's synchronized bit is 1 with done=0, its count latches the counter value and done is set.
  - Exit to EVAL the cycle after all done flags are set, or after the cycle in which counter == CHARGE_TIMEOUT.
  - In the timeout cycle, pads with done=0 latch CHARGE_TIMEOUT.
  - A pad already high on CHARGE entry latches 0.
- EVAL (1 cycle): sensors_out=0.
  - raw[i] = count[i] > threshold, unsigned compare; threshold is sampled in this cycle.
  - touched[i] <= raw[i] if raw[i] == raw_prev[i], else it holds (2-scan agreement). Then raw_prev <= raw.
  - scan_done=1 in this cycle; touched updates at the end of it.
  - Next state: DISCHARGE if enable=1, else IDLE.
- enable falling mid-scan: the scan completes normally, including scan_done, then goes to IDLE. enable rising in IDLE starts a scan on the next cycle.
- count_out is combinational from the latched counts and count_sel; it is stable except during CHARGE latching.
- Counter width: CHARGE_TIMEOUT and DISCHARGE_CYCLES must each be < 2^CNT_W. No wrap is possible.
- touched is never altered outside EVAL.

Test Plan:
1. Reset: assert reset=0 with enable=1 and random sensors_in -> sensors_out=0, touched=0, busy=0, scan_done=0, count_out=0 for every count_sel.
2. Latency/count: DISCHARGE_CYCLES=4, CHARGE_TIMEOUT=100, enable=1; drive sensors_in[3]=1 after the clock edge where counter=20, all other pads at counter=5 -> count_sel=3 reads 22, the other pads read 7; sensors_out is low for exactly 4 cycles before CHARGE; scan_done pulses one cycle.
3. Debounce: threshold=30, pad 3 count=40 in scan 1 -> touched[3]=0 after scan 1 and =1 after scan 2; pad 3 count=10 in scan 3 -> touched[3] stays 1; scan 4 with count=10 -> touched[3]=0.
4. Timeout: pad 5 never rises, CHARGE_TIMEOUT=100 -> count 100, CHARGE lasts 101 cycles, raw[5]=1 when threshold=30.
5. Stop: deassert enable in mid-CHARGE -> scan finishes, scan_done pulses once, then IDLE with sensors_out=0 and busy=0, and no further DISCHARGE.
6. Abort: assert reset=0 in mid-CHARGE -> sensors_out=0 before the next clock edge, no scan_done; after release with enable=1, a fresh DISCHARGE begins one cycle later.
